// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble) with start/done handshake.
// Optional leading-zero blanking output when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int unsigned SW     = 4 * DIGITS;
    localparam int unsigned CntW   = $clog2(WIDTH + 1);
    localparam logic [31:0] MaxVal = 32'(10 ** DIGITS - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  op_q;
    logic [SW-1:0]     scratch_q;
    logic [CntW-1:0]   count_q;
    logic              ovf_pend_q;
    logic              busy_q;
    logic              done_q;
    logic [SW-1:0]     digits_q;
    logic              ovf_q;

    logic [SW-1:0]     adj;
    logic [SW-1:0]     scratch_d;
    logic              ovf_pend_d;
    logic              unused_carry;

    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        scratch_d  = {adj[SW-2:0], op_q[WIDTH-1]};
        ovf_pend_d = ({{(32-WIDTH){1'b0}}, bin} > MaxVal);
    end

    // The carry out of the top digit is dropped: on overflow only the low digits survive.
    assign unused_carry = adj[SW-1];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;
    logic              lead;

    always_comb begin
        blank_d = '0;
        lead    = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            lead       = lead & (scratch_d[4*k +: 4] == 4'd0);
            blank_d[k] = lead;
        end
        blank_d[0] = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q       <= bin;
                        scratch_q  <= '0;
                        ovf_pend_q <= ovf_pend_d;
                        count_q    <= CntW'(WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    op_q      <= op_q << 1;
                    scratch_q <= scratch_d;
                    count_q   <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        digits_q <= scratch_d;
                        ovf_q    <= ovf_pend_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
`ifdef BIN2BCD_BLANK_EN
                        blank_q  <= blank_d;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign digits = digits_q;
    assign ovf    = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    assign blank  = blank_q;
`endif

`ifndef SYNTHESIS
    initial begin
        if (WIDTH < 4 || WIDTH > 16) $fatal(1, "bin2bcd_seq: WIDTH %0d out of range", WIDTH);
        if (DIGITS < 1 || DIGITS > 5) $fatal(1, "bin2bcd_seq: DIGITS %0d out of range", DIGITS);
    end
`endif

endmodule
